// File: rtl/insert_sched_pkg.sv
// insert_sched_pkg: scheduler state encodings and segment-size sanitiser shared by insert_seg_sched.
package insert_sched_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HELD   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    // Returns {err, size}: bit 0 cleared, then clamped to max_bytes (which must be even).
    function automatic logic [8:0] sanitize_size(input logic [7:0] size, input logic [7:0] max_bytes);
        logic [7:0] even;
        even = {size[7:1], 1'b0};
        return {size[0] | (size > max_bytes), (even > max_bytes) ? max_bytes : even};
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);

    // Scan from the farthest offset down so the nearest request at or above ptr wins.
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NUM_REQ]) idx = IW'((int'(ptr) + k) % NUM_REQ);
    end

    assign any = |req;
    assign gnt = any ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/insert_seg_sched.sv
// insert_seg_sched: per-packet round-robin segment scheduler gating the stream into the header inserter.
// Define INSERT_SCHED_STALL_EN to stall packets until a segment is available instead of bypassing them.
module insert_seg_sched
    import insert_sched_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int MAX_INSERT_BYTES = 4,
    parameter int SIZE_CBITS       = $clog2(MAX_INSERT_BYTES + 1),
    parameter int CNT_WIDTH        = 32
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*SIZE_CBITS-1:0]        req_size,
    input  logic [NUM_REQ*MAX_INSERT_BYTES*8-1:0] req_data,
    input  logic                                 in_tvalid,
    input  logic                                 in_tlast,
    output logic                                 in_tready,
    output logic                                 out_tvalid,
    input  logic                                 out_tready,
    output logic [SIZE_CBITS-1:0]                seg_size,
    output logic [MAX_INSERT_BYTES*8-1:0]        seg_data,
    output logic [$clog2(NUM_REQ)-1:0]           seg_src,
    output logic                                 seg_src_valid,
    output logic                                 err_size,
    output logic [CNT_WIDTH-1:0]                 ins_pkt_cnt
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int DW = MAX_INSERT_BYTES * 8;

    logic [1:0]         state, state_nxt;
    logic [IW-1:0]      rr_ptr, win_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               any_req, idle, grant, bypass, beat, san_err;
    logic [8:0]         san;
    logic [SIZE_CBITS-1:0] win_size, san_size;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(req_valid),
        .ptr(rr_ptr),
        .gnt(gnt),
        .idx(win_idx),
        .any(any_req)
    );

    assign idle  = state == IDLE;
    assign grant = idle & any_req;
`ifdef INSERT_SCHED_STALL_EN
    assign bypass = 1'b0;
`else
    assign bypass = idle & ~any_req & in_tvalid;
`endif
    assign beat       = in_tvalid & out_tready;
    assign req_ready  = grant ? gnt : '0;
    assign out_tvalid = ~idle & in_tvalid;
    assign in_tready  = ~idle & out_tready;

    assign win_size = req_size[win_idx*SIZE_CBITS +: SIZE_CBITS];
    assign san      = sanitize_size(8'(win_size), 8'(MAX_INSERT_BYTES));
    assign san_size = san[SIZE_CBITS-1:0];
    assign san_err  = san[8] | (|(san[7:0] >> SIZE_CBITS));

    always_comb
        state_nxt = idle ? ((grant | bypass) ? HELD : IDLE) :
                    (state == HELD) ? (beat ? (in_tlast ? IDLE : ACTIVE) : HELD) :
                    ((beat & in_tlast) ? IDLE : ACTIVE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            seg_size      <= '0;
            seg_data      <= '0;
            seg_src       <= '0;
            seg_src_valid <= 1'b0;
            err_size      <= 1'b0;
            ins_pkt_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                rr_ptr        <= IW'((int'(win_idx) + 1) % NUM_REQ);
                seg_size      <= san_size;
                seg_data      <= req_data[win_idx*DW +: DW];
                seg_src       <= win_idx;
                seg_src_valid <= 1'b1;
                err_size      <= err_size | san_err;
                if (san_size != '0) ins_pkt_cnt <= ins_pkt_cnt + 1'b1;
            end else if (bypass) begin
                seg_size      <= '0;
                seg_data      <= '0;
                seg_src       <= '0;
                seg_src_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_insert_seg_sched.sv
// tb_insert_seg_sched: directed table-driven bench for insert_seg_sched with default parameters.
module tb_insert_seg_sched;
    logic         aclk = 1'b0;
    logic         aresetn;
    logic [3:0]   req_valid, req_ready;
    logic [11:0]  req_size;
    logic [127:0] req_data;
    logic         in_tvalid, in_tlast, in_tready, out_tvalid, out_tready;
    logic [2:0]   seg_size;
    logic [31:0]  seg_data;
    logic [1:0]   seg_src;
    logic         seg_src_valid, err_size;
    logic [31:0]  ins_pkt_cnt;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  rv;
        logic [11:0] sizes;
        int          src;
        int          size;
        logic        err;
        int          cnt;
    } vec_t;
    vec_t vt[10];

    insert_seg_sched dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size), .req_data(req_data),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .seg_size(seg_size), .seg_data(seg_data), .seg_src(seg_src),
        .seg_src_valid(seg_src_valid), .err_size(err_size), .ins_pkt_cnt(ins_pkt_cnt)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] src_data(input int i);
        return (i == 0) ? 32'h11223344 : 32'hA0B0C0D0 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        req_valid = '0; req_size = '0;
        in_tvalid = 1'b0; in_tlast = 1'b0; out_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("rst seg_size", 64'(seg_size), 0);
        check("rst seg_data", 64'(seg_data), 0);
        check("rst seg_src", 64'(seg_src), 0);
        check("rst src_valid", 64'(seg_src_valid), 0);
        check("rst err_size", 64'(err_size), 0);
        check("rst cnt", 64'(ins_pkt_cnt), 0);
        check("rst out_tvalid", 64'(out_tvalid), 0);
        check("rst in_tready", 64'(in_tready), 0);
        check("rst req_ready", 64'(req_ready), 0);
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = src_data(i);
        vt[0] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd4}, 0, 4, 1'b0, 1};
        vt[1] = '{4'b0011, {3'd0, 3'd0, 3'd2, 3'd2}, 1, 2, 1'b0, 2};
        vt[2] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 0, 0, 1'b0, 2};
        vt[3] = '{4'b1100, {3'd2, 3'd4, 3'd0, 3'd0}, 2, 4, 1'b0, 3};
        vt[4] = '{4'b1101, {3'd4, 3'd2, 3'd0, 3'd2}, 3, 4, 1'b0, 4};
        vt[5] = '{4'b0110, {3'd0, 3'd4, 3'd2, 3'd0}, 1, 2, 1'b0, 5};
        vt[6] = '{4'b0010, {3'd0, 3'd0, 3'd3, 3'd0}, 1, 2, 1'b1, 6};
        vt[7] = '{4'b1000, {3'd6, 3'd0, 3'd0, 3'd0}, 3, 4, 1'b1, 7};
        vt[8] = '{4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 2, 4, 1'b1, 8};
        vt[9] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd7}, 0, 4, 1'b1, 9};

        do_reset();

        // Single source, 3-beat packet
        req_size = {3'd0, 3'd0, 3'd0, 3'd4};
        req_valid = 4'b0001;
        #1 check("ss req_ready", 64'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        #1 check("ss pop once", 64'(req_ready), 0);
        check("ss seg_data", 64'(seg_data), 32'h11223344);
        check("ss cnt", 64'(ins_pkt_cnt), 1);
        in_tvalid = 1'b1; out_tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_tlast = (b == 2);
            #1;
            check("ss out_tvalid", 64'(out_tvalid), 1);
            check("ss in_tready", 64'(in_tready), 1);
            check("ss seg_size", 64'(seg_size), 4);
            tick();
        end
        #1;
        check("ss idle out_tvalid", 64'(out_tvalid), 0);
        check("ss idle in_tready", 64'(in_tready), 0);
        in_tvalid = 1'b0; in_tlast = 1'b0;
        check("ss cnt hold", 64'(ins_pkt_cnt), 1);

        // Table: grants, round-robin order, sanitising, counter
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req_valid = vt[i].rv;
            req_size = vt[i].sizes;
            #1 check($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(1) << vt[i].src);
            tick();
            req_valid = '0;
            check($sformatf("v%0d seg_src", i), 64'(seg_src), 64'(vt[i].src));
            check($sformatf("v%0d seg_size", i), 64'(seg_size), 64'(vt[i].size));
            check($sformatf("v%0d seg_data", i), 64'(seg_data), 64'(src_data(vt[i].src)));
            check($sformatf("v%0d err_size", i), 64'(err_size), 64'(vt[i].err));
            check($sformatf("v%0d cnt", i), 64'(ins_pkt_cnt), 64'(vt[i].cnt));
            check($sformatf("v%0d src_valid", i), 64'(seg_src_valid), 1);
            in_tvalid = 1'b1; in_tlast = 1'b1; out_tready = 1'b1;
            #1 check($sformatf("v%0d out_tvalid", i), 64'(out_tvalid), 1);
            tick();
            in_tvalid = 1'b0; in_tlast = 1'b0;
        end

        // No request pending
        in_tvalid = 1'b1; in_tlast = 1'b1; out_tready = 1'b1;
`ifdef INSERT_SCHED_STALL_EN
        for (int c = 0; c < 10; c++) begin
            #1 check("stall out_tvalid", 64'(out_tvalid), 0);
            tick();
        end
        req_size = {3'd0, 3'd0, 3'd0, 3'd2};
        req_valid = 4'b0001;
        #1 check("stall req_ready", 64'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        check("stall out_tvalid open", 64'(out_tvalid), 1);
        check("stall seg_size", 64'(seg_size), 2);
        check("stall cnt", 64'(ins_pkt_cnt), 10);
        tick();
`else
        #1 check("byp closed", 64'(out_tvalid), 0);
        tick();
        check("byp out_tvalid", 64'(out_tvalid), 1);
        check("byp seg_size", 64'(seg_size), 0);
        check("byp seg_data", 64'(seg_data), 0);
        check("byp src_valid", 64'(seg_src_valid), 0);
        check("byp cnt", 64'(ins_pkt_cnt), 9);
        tick();
`endif
        in_tvalid = 1'b0; in_tlast = 1'b0;

        // Round-robin fairness, 8 one-beat packets
        do_reset();
        req_size = {3'd2, 3'd2, 3'd2, 3'd2};
        req_valid = 4'b1111;
        for (int p = 0; p < 8; p++) begin
            #1 check($sformatf("rr%0d req_ready", p), 64'(req_ready), 64'(1) << (p % 4));
            tick();
            check($sformatf("rr%0d seg_src", p), 64'(seg_src), 64'(p % 4));
            in_tvalid = 1'b1; in_tlast = 1'b1;
            tick();
            in_tvalid = 1'b0; in_tlast = 1'b0;
        end
        req_valid = '0;

        // Backpressure with a new request raised mid-packet
        do_reset();
        req_size = {3'd0, 3'd0, 3'd2, 3'd4};
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        in_tvalid = 1'b1; in_tlast = 1'b0;
        for (int k = 0; k < 6; k++) begin
            out_tready = k[0];
            if (k == 2) req_valid = 4'b0010;
            #1;
            check($sformatf("bp%0d req_ready", k), 64'(req_ready), 0);
            check($sformatf("bp%0d seg_size", k), 64'(seg_size), 4);
            check($sformatf("bp%0d in_tready", k), 64'(in_tready), 64'(k[0]));
            tick();
        end
        in_tlast = 1'b1; out_tready = 1'b1;
        #1 check("bp last req_ready", 64'(req_ready), 0);
        tick();
        in_tvalid = 1'b0; in_tlast = 1'b0;
        #1 check("bp idle req_ready", 64'(req_ready), 4'b0010);
        check("bp idle seg_size", 64'(seg_size), 4);
        tick();
        req_valid = '0;
        check("bp new seg_size", 64'(seg_size), 2);
        check("bp new seg_src", 64'(seg_src), 1);

        // Asynchronous reset during beat 2 of a 4-beat packet
        do_reset();
        req_size = {3'd0, 3'd4, 3'd0, 3'd0};
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        in_tvalid = 1'b1; in_tlast = 1'b0; out_tready = 1'b1;
        tick();
        #2 aresetn = 1'b0;
        #1;
        check("mid out_tvalid", 64'(out_tvalid), 0);
        check("mid in_tready", 64'(in_tready), 0);
        check("mid seg_size", 64'(seg_size), 0);
        check("mid seg_data", 64'(seg_data), 0);
        check("mid seg_src", 64'(seg_src), 0);
        check("mid src_valid", 64'(seg_src_valid), 0);
        check("mid cnt", 64'(ins_pkt_cnt), 0);
        in_tvalid = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        req_size = {3'd2, 3'd2, 3'd2, 3'd2};
        req_valid = 4'b1111;
        #1 check("mid rr_ptr zero", 64'(req_ready), 4'b0001);
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/insert_seg_sched.md
# insert_seg_sched

Per-packet scheduler for the NMU dynamic header inserter. It arbitrates round-robin among `NUM_REQ` segment sources, such as VLAN tags or virtualization headers. It latches the winning segment and size, and holds `seg_size` and `seg_data` stable from before the first beat of a packet until its `tlast` handshake. It sits between the ingress AXI Stream FIFO and the inserter FSM, and gates the packet's `tvalid`/`tready` so that no beat reaches the inserter while no segment is latched.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of segment sources, range 2..16.
- `MAX_INSERT_BYTES`, default 4: maximum segment length in bytes; must be even.
- `SIZE_CBITS`, default `$clog2(MAX_INSERT_BYTES+1)`: width of a segment size field (derived).
- `CNT_WIDTH`, default 32: width of the inserted-packet counter.

Ports (reset is asynchronous, active-low):
- `aclk` in 1: the single clock.
- `aresetn` in 1: asynchronous active-low reset.
- `req_valid` in `NUM_REQ`: source i has a segment descriptor pending.
- `req_ready` out `NUM_REQ`: one-hot pop pulse to the granted source.
- `req_size` in `NUM_REQ*SIZE_CBITS`: packed per-source segment size in bytes.
- `req_data` in `NUM_REQ*MAX_INSERT_BYTES*8`: packed per-source segment bytes, byte 0 at LSB.
- `in_tvalid` in 1: upstream beat valid.
- `in_tlast` in 1: upstream beat is the last beat of the packet.
- `in_tready` out 1: upstream ready; equals `out_tready` when the gate is open, else 0.
- `out_tvalid` out 1: `in_tvalid` when the gate is open, else 0.
- `out_tready` in 1: ready from the inserter.
- `seg_size` out `SIZE_CBITS`: latched segment size, driven to the inserter.
- `seg_data` out `MAX_INSERT_BYTES*8`: latched segment bytes.
- `seg_src` out `$clog2(NUM_REQ)`: index of the granted source.
- `seg_src_valid` out 1: `seg_src` is meaningful; 0 when bypassing.
- `err_size` out 1: sticky flag for an odd or oversize request; cleared only by reset.
- `ins_pkt_cnt` out `CNT_WIDTH`: count of packets that received a non-zero segment; wraps.

## Operation
- The state machine has three states: IDLE, HELD, ACTIVE.
- **IDLE** (gate closed):
  - If any `req_valid` is high, grant the round-robin winner: search from `rr_ptr` upward, modulo `NUM_REQ`.
  - On the grant, pulse `req_ready[w]` for one cycle; in the same cycle latch the winner's size, data and index, and set `seg_src_valid`=1.
  - Next state is HELD; set `rr_ptr` = w+1 mod `NUM_REQ`.
- **IDLE bypass:** with no `req_valid` but `in_tvalid` high, behaviour depends on the configuration macro (see Configuration).
- **HELD** (gate open): on `in_tvalid && out_tready` go to ACTIVE. If that beat also has `in_tlast` high (single-beat packet), go directly to IDLE instead.
- **ACTIVE** (gate open): on `in_tvalid && out_tready && in_tlast` go to IDLE. The latched segment stays valid through that beat.
- **Latched outputs:** `seg_size`, `seg_data` and `seg_src` change only on the IDLE-exit edge; they are never modified in HELD or ACTIVE.
- **Size sanitising at latch:**
  - An odd size has bit 0 cleared.
  - A size greater than `MAX_INSERT_BYTES` is clamped to `MAX_INSERT_BYTES`.
  - Either case sets `err_size`.
- **Counter:** `ins_pkt_cnt` increments on each IDLE-exit whose latched `seg_size` is non-zero.
- **Request ownership:** once granted, a request is owned by the block. If `req_valid` drops during HELD or ACTIVE it has no effect.

## Timing
- **Reset values:**
  - state = IDLE, `rr_ptr` = 0
  - `req_ready`, `in_tready`, `out_tvalid` = 0
  - `seg_size`, `seg_data`, `seg_src`, `seg_src_valid`, `err_size`, `ins_pkt_cnt` = 0
- **Grant latency:** `req_valid` high in IDLE at cycle t gives `req_ready` at t (combinational). The latch lands at t+1, with the gate open from t+1.
- **First-beat latency:** one bubble per packet in the IDLE→HELD cycle. Back-to-back packets therefore have one idle cycle between the `tlast` beat and the next first beat.
- **Gate handshake:** `out_tvalid` and `in_tready` are combinational from the state and `in_tvalid`/`out_tready`. There is no combinational path from `req_*` to `out_tvalid`.
- **`tlast` and new request in the same cycle:** the block enters IDLE first; the new grant happens on the next cycle.
- **Reset mid-packet:** all state clears immediately (asynchronous). The partial packet is the upstream's responsibility; no recovery is attempted.
- **Simultaneous requests:** only one grant per IDLE cycle, strictly round-robin.

## Configuration
- `INSERT_SCHED_STALL_EN` defined: in IDLE with no request pending, the gate stays closed and the packet stalls until a segment arrives, so every packet receives a segment.
- `INSERT_SCHED_STALL_EN` undefined: in IDLE with `in_tvalid` high and no `req_valid`, latch `seg_size`=0, `seg_data`=0, `seg_src_valid`=0 and go to HELD. The packet then passes unmodified after the same one-cycle bubble.

## Structure
- **Package `insert_sched_pkg`:** holds the state enum (IDLE/HELD/ACTIVE) and a `sanitize_size` function that clears bit 0, clamps, and returns an error bit.
- **Sub-module `rr_arbiter`:** parameterised by `NUM_REQ`. Inputs are the request vector and `rr_ptr`; outputs are a one-hot grant, an encoded index and an any-request flag. It is purely combinational, and the pointer register lives in the parent.

## Test plan
- **Single source:** source 0 with size 4, data 0x11223344, then a 3-beat packet → `req_ready[0]` pulses once; `seg_size`=4 is stable across all 3 beats; `ins_pkt_cnt`=1; state returns to IDLE after the `tlast` beat.
- **Round-robin fairness:** all 4 sources valid continuously, 8 one-beat packets → `seg_src` sequence is 0,1,2,3,0,1,2,3.
- **Size sanitising:** `req_size`=3 → `seg_size`=2 and `err_size`=1; `req_size`=6 with `MAX_INSERT_BYTES`=4 → `seg_size`=4.
- **No request pending:**
  - With the macro: `in_tvalid` held for 10 cycles with no request gives `out_tvalid`=0 throughout; a request at cycle 10 gives the first beat accepted at cycle 11.
  - Without the macro: the first beat passes at cycle 1 with `seg_size`=0 and `ins_pkt_cnt` unchanged.
- **Backpressure:** `out_tready` toggled every cycle mid-packet, with a new `req_valid` raised during ACTIVE → `seg_size` is unchanged until after the `tlast` handshake, and `req_ready` fires only in IDLE.
- **Reset mid-packet:** `aresetn` asserted during beat 2 of a 4-beat packet → all outputs are 0 asynchronously and `rr_ptr` = 0.
